// File: rtl/bcd_stopwatch_lap_pkg.sv
// Shared types and helpers for the BCD stopwatch.
//   sw_state_e  : stopwatch control states
//   BLANK_SEG   : active-high segment pattern for a dark digit
//   seg7_decode : BCD digit to active-high gfedcba segment pattern
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLap,
        StPause
    } sw_state_e;

    localparam logic [6:0] BLANK_SEG = 7'b0000000;

    // Codes 10..15 should never occur; they decode blank rather than garbage.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = BLANK_SEG;
        case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = BLANK_SEG;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_lap_digit.sv
// One BCD decade of the stopwatch counter.
//   Clk, Rst : clock, synchronous active-high reset
//   clr      : synchronous clear (soft clear from the control FSM)
//   inc      : advance this decade by one
//   q        : current digit value, always 0..9
//   carry    : inc while at 9, i.e. this decade wraps; feeds the next decade's inc
module bcd_digit (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] digit_q;

    assign carry = inc & (digit_q == 4'd9);
    assign q     = digit_q;

    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            digit_q <= 4'd0;
        end else if (inc) begin
            digit_q <= carry ? 4'd0 : digit_q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_lap.sv
// BCD stopwatch with lap-hold display.
//   Clk, Rst  : clock, synchronous active-high reset
//   Start     : rising edge starts/resumes counting
//   Stop      : rising edge pauses counting
//   Lap       : rising edge toggles lap-hold; in PAUSE it clears back to IDLE
//   Count     : live BCD count, digit 0 in [3:0]
//   Hex       : seven-segment drive of the displayed value, digit i in [7i+6:7i], gfedcba
//   Running   : counting (RUN or LAP)
//   LapHeld   : display frozen on the lap register
//   Overflow  : sticky, set when the count wraps from all nines
// Parameters: CLK_HZ / TICK_HZ must divide to an integer of at least 2; DIGITS in 1..8.
module bcd_stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned TICK_HZ        = 100,
    parameter int unsigned DIGITS         = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic                  Lap,
    output logic [4*DIGITS-1:0]   Count,
    output logic [7*DIGITS-1:0]   Hex,
    output logic                  Running,
    output logic                  LapHeld,
    output logic                  Overflow
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    // Request inputs are sampled once, then compared against the previous sample,
    // so an event is one cycle wide no matter how long the request is held.
    logic start_q, start_prev_q;
    logic stop_q, stop_prev_q;
    logic lap_q, lap_prev_q;
    logic start_ev, stop_ev, lap_ev;

    sw_state_e state_q, state_d;
    logic      lap_load, soft_clr;
    logic      counting, tick;

    logic [PW-1:0]         presc_q;
    logic [4*DIGITS-1:0]   count_w;
    logic [4*DIGITS-1:0]   lap_val_q;
    logic [4*DIGITS-1:0]   disp_w;
    logic [DIGITS:0]       inc_chain;
    logic                  running_q, lap_held_q, overflow_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            stop_q       <= 1'b0;
            stop_prev_q  <= 1'b0;
            lap_q        <= 1'b0;
            lap_prev_q   <= 1'b0;
        end else begin
            start_q      <= Start;
            start_prev_q <= start_q;
            stop_q       <= Stop;
            stop_prev_q  <= stop_q;
            lap_q        <= Lap;
            lap_prev_q   <= lap_q;
        end
    end

    assign start_ev = start_q & ~start_prev_q;
    assign stop_ev  = stop_q & ~stop_prev_q;
    assign lap_ev   = lap_q & ~lap_prev_q;

    // Only one event acts per cycle: Stop, then Start, then Lap. A Stop in IDLE
    // is ignored but still masks a simultaneous Start.
    always_comb begin
        state_d  = state_q;
        lap_load = 1'b0;
        soft_clr = 1'b0;
        if (stop_ev) begin
            if (state_q == StRun || state_q == StLap) begin
                state_d = StPause;
            end
        end else if (start_ev) begin
            if (state_q == StIdle || state_q == StPause) begin
                state_d = StRun;
            end
        end else if (lap_ev) begin
            case (state_q)
                StRun: begin
                    state_d  = StLap;
                    lap_load = 1'b1;
                end
                StLap:   state_d = StRun;
                StPause: begin
                    state_d  = StIdle;
                    soft_clr = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StIdle;
            running_q  <= 1'b0;
            lap_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= (state_d == StRun) || (state_d == StLap);
            lap_held_q <= (state_d == StLap);
        end
    end

    assign counting = (state_q == StRun) || (state_q == StLap);
    assign tick     = counting && (presc_q == PW'(DIV - 1));

    // Prescaler is frozen, not cleared, in PAUSE so a resume keeps the partial interval.
    always_ff @(posedge Clk) begin
        if (Rst || soft_clr) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else if (counting) begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign inc_chain[0] = tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .Clk   (Clk),
            .Rst   (Rst),
            .clr   (soft_clr),
            .inc   (inc_chain[g]),
            .q     (count_w[4*g +: 4]),
            .carry (inc_chain[g+1])
        );
    end

    // Latch uses the pre-increment count even when a tick lands on the same edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            lap_val_q <= '0;
        end else if (lap_load) begin
            lap_val_q <= count_w;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || soft_clr) begin
            overflow_q <= 1'b0;
        end else if (inc_chain[DIGITS]) begin
            overflow_q <= 1'b1;
        end
    end

    assign disp_w = lap_held_q ? lap_val_q : count_w;

    for (genvar h = 0; h < DIGITS; h++) begin : g_hex
        logic [6:0] seg;
        assign seg = seg7_decode(disp_w[4*h +: 4]);
        assign Hex[7*h +: 7] = SEG_ACTIVE_LOW ? ~seg : seg;
    end

    assign Count    = count_w;
    assign Running  = running_q;
    assign LapHeld  = lap_held_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_lap.sv
// Directed bench for bcd_stopwatch_lap with CLK_HZ=10, TICK_HZ=1 (DIV=10), DIGITS=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_bcd_stopwatch_lap;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H5 = 7'b0010010;
    localparam logic [6:0] H8 = 7'b0000000;
    localparam logic [6:0] H9 = 7'b0010000;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic        Stop;
    logic        Lap;
    logic [7:0]  Count;
    logic [13:0] Hex;
    logic        Running;
    logic        LapHeld;
    logic        Overflow;

    int errors = 0;
    int checks = 0;

    bcd_stopwatch_lap #(
        .CLK_HZ         (10),
        .TICK_HZ        (1),
        .DIGITS         (2),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Stop     (Stop),
        .Lap      (Lap),
        .Count    (Count),
        .Hex      (Hex),
        .Running  (Running),
        .LapHeld  (LapHeld),
        .Overflow (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst   = 1'b1;
        Start = 1'b0;
        Stop  = 1'b0;
        Lap   = 1'b0;
        step(2);
        check("rst_count",    16'(Count),    16'h00);
        check("rst_running",  16'(Running),  16'h0);
        check("rst_lapheld",  16'(LapHeld),  16'h0);
        check("rst_overflow", 16'(Overflow), 16'h0);
        check("rst_hex",      16'(Hex),      16'({H0, H0}));
        Rst = 1'b0;

        // Scenario 1: start, first increment after DIV cycles, decade carry.
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        check("start_latency", 16'(Running), 16'h0);
        step(1);
        check("start_running", 16'(Running), 16'h1);
        check("start_lapheld", 16'(LapHeld), 16'h0);
        step(9);
        check("cnt_before_1st", 16'(Count), 16'h00);
        step(1);
        check("cnt_first_tick", 16'(Count), 16'h01);
        step(89);
        check("cnt_09", 16'(Count), 16'h09);
        step(1);
        check("cnt_10_carry", 16'(Count), 16'h10);

        // Scenario 2: wrap from 99 sets sticky overflow.
        step(890);
        check("cnt_99", 16'(Count), 16'h99);
        check("hex_99", 16'(Hex),   16'({H9, H9}));
        step(9);
        check("cnt_99_hold", 16'(Count),    16'h99);
        check("ovf_pre",     16'(Overflow), 16'h0);
        step(1);
        check("cnt_wrap", 16'(Count),    16'h00);
        check("ovf_set",  16'(Overflow), 16'h1);
        step(10);
        check("cnt_after_wrap", 16'(Count),    16'h01);
        check("ovf_sticky",     16'(Overflow), 16'h1);

        // Scenario 3: lap hold at 05 while live count advances to 08.
        step(42);
        Lap = 1'b1;
        step(1);
        Lap = 1'b0;
        step(1);
        check("lap_held",    16'(LapHeld), 16'h1);
        check("lap_running", 16'(Running), 16'h1);
        check("lap_hex_05",  16'(Hex),     16'({H0, H5}));
        step(26);
        check("lap_live_08",  16'(Count), 16'h08);
        check("lap_hex_froz", 16'(Hex),   16'({H0, H5}));
        Lap = 1'b1;
        step(1);
        Lap = 1'b0;
        step(1);
        check("unlap_held",  16'(LapHeld), 16'h0);
        check("unlap_hex",   16'(Hex),     16'({H0, H8}));
        check("unlap_count", 16'(Count),   16'h08);

        // Scenario 4: stop with prescaler at 4, resume 20 cycles later.
        Stop = 1'b1;
        step(1);
        Stop = 1'b0;
        step(1);
        check("pause_running", 16'(Running), 16'h0);
        step(20);
        check("pause_count", 16'(Count), 16'h08);
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(1);
        check("resume_running", 16'(Running), 16'h1);
        check("resume_count",   16'(Count),   16'h08);
        step(5);
        check("resume_5cyc", 16'(Count), 16'h08);
        step(1);
        check("resume_6cyc", 16'(Count), 16'h09);

        // Scenario 5: soft clear from PAUSE, held Start gives a single event.
        Stop = 1'b1;
        step(1);
        Stop = 1'b0;
        step(1);
        check("pause2_running", 16'(Running),  16'h0);
        check("pause2_ovf",     16'(Overflow), 16'h1);
        Lap = 1'b1;
        step(1);
        Lap = 1'b0;
        step(1);
        check("clr_count",   16'(Count),    16'h00);
        check("clr_ovf",     16'(Overflow), 16'h0);
        check("clr_running", 16'(Running),  16'h0);
        check("clr_lapheld", 16'(LapHeld),  16'h0);
        check("clr_hex",     16'(Hex),      16'({H0, H0}));
        Start = 1'b1;
        step(2);
        check("hold_running", 16'(Running), 16'h1);
        step(20);
        check("hold_count", 16'(Count), 16'h02);
        Stop = 1'b1;
        step(1);
        Stop = 1'b0;
        step(1);
        check("hold_stop", 16'(Running), 16'h0);
        step(26);
        check("hold_no_restart", 16'(Running), 16'h0);
        check("hold_cnt_frozen", 16'(Count),   16'h02);
        Start = 1'b0;
        step(2);
        check("release_running", 16'(Running), 16'h0);

        // Scenario 6: simultaneous Start+Stop in IDLE, then reset during RUN.
        Lap = 1'b1;
        step(1);
        Lap = 1'b0;
        step(1);
        check("idle_count", 16'(Count), 16'h00);
        Start = 1'b1;
        Stop  = 1'b1;
        step(1);
        Start = 1'b0;
        Stop  = 1'b0;
        step(1);
        check("both_idle", 16'(Running), 16'h0);
        step(6);
        check("both_idle_late", 16'(Running), 16'h0);
        check("both_idle_cnt",  16'(Count),   16'h00);
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(1);
        check("run_again", 16'(Running), 16'h1);
        step(15);
        check("run_again_cnt", 16'(Count), 16'h01);
        Rst = 1'b1;
        Lap = 1'b1;
        step(1);
        check("mid_rst_count",   16'(Count),    16'h00);
        check("mid_rst_running", 16'(Running),  16'h0);
        check("mid_rst_lapheld", 16'(LapHeld),  16'h0);
        check("mid_rst_ovf",     16'(Overflow), 16'h0);
        check("mid_rst_hex",     16'(Hex),      16'({H0, H0}));
        Rst = 1'b0;
        Lap = 1'b0;
        step(3);
        check("post_rst_running", 16'(Running), 16'h0);
        check("post_rst_count",   16'(Count),   16'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
